// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents: RISC-V funct3 size encodings, the FSM state type, and
// helpers that decide alignment and legality of a request.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Halfwords need an even address, words need a 4-byte aligned address.
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic ok;
    case (funct3)
      F3_H, F3_HU: ok = (addr_lo[0] == 1'b0);
      F3_W:        ok = (addr_lo == 2'b00);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Encoding legality: 011/110/111 never exist, and unsigned sizes make
  // no sense for stores.
  function automatic logic is_legal_f3(input logic [2:0] funct3, input logic is_store);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align_extend.sv
// Combinational load data extraction.
// Ports:
//   word    - full 32-bit word read from memory
//   addr_lo - low two bits of the byte address (byte/half lane select)
//   funct3  - access size/sign encoding
//   result  - lane extracted and sign/zero extended to XLEN
module load_align_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and halfword lanes.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'b00:   byte_s = word[7:0];
      2'b01:   byte_s = word[15:8];
      2'b10:   byte_s = word[23:16];
      2'b11:   byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
  end

  // Extend the selected lane according to the access size.
  always_comb begin
    result = {XLEN{1'b0}};
    case (funct3)
      F3_B:    result = {{24{byte_s[7]}}, byte_s};
      F3_BU:   result = {24'h000000, byte_s};
      F3_H:    result = {{16{half_s[15]}}, half_s};
      F3_HU:   result = {16'h0000, half_s};
      F3_W:    result = word;
      default: result = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store in flight at a time.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   req_*                        - request handshake from execute stage
//   resp_*                       - response handshake (data, error)
//   mem_addr/read/write strobes  - word-addressed memory, comb read,
//                                  posedge write
// Sub-word stores are read-modify-write (RD then WR). Illegal or
// misaligned requests respond with an error and never strobe memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  output logic [XLEN-1:0]       mem_write_data,
  input  logic [XLEN-1:0]       mem_read_data
);

  lsu_state_t            state_r;
  logic                  req_ready_r;
  logic                  resp_valid_r;
  logic                  resp_error_r;
  logic                  rd_en_r;
  logic                  wr_en_r;
  logic                  is_store_r;
  logic [2:0]            funct3_r;
  logic [1:0]            addr_lo_r;
  logic [XLEN-1:0]       wdata_r;
  logic [XLEN-1:0]       resp_rdata_r;
  logic [XLEN-1:0]       mem_wdata_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [ADDR_WIDTH-1:0] req_word_addr_s;
  logic [XLEN-1:0]       load_ext_s;
  logic [XLEN-1:0]       merge_word_s;
  logic                  req_legal_s;
  logic                  accept_s;

  assign req_word_addr_s = {req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign req_legal_s     = is_legal_f3(req_funct3, req_is_store) &&
                           is_aligned(req_funct3, req_addr[1:0]);
  assign accept_s        = req_valid && req_ready_r;

  load_align_extend #(.XLEN(XLEN)) u_extend (
    .word    (mem_read_data),
    .addr_lo (addr_lo_r),
    .funct3  (funct3_r),
    .result  (load_ext_s)
  );

  // Store merge: same lane selection as the load path, replacing only the
  // addressed byte/half in the freshly read word.
  always_comb begin
    merge_word_s = mem_read_data;
    case (funct3_r)
      F3_B: begin
        case (addr_lo_r)
          2'b00:   merge_word_s = {mem_read_data[31:8], wdata_r[7:0]};
          2'b01:   merge_word_s = {mem_read_data[31:16], wdata_r[7:0], mem_read_data[7:0]};
          2'b10:   merge_word_s = {mem_read_data[31:24], wdata_r[7:0], mem_read_data[15:0]};
          2'b11:   merge_word_s = {wdata_r[7:0], mem_read_data[23:0]};
          default: merge_word_s = mem_read_data;
        endcase
      end
      F3_H: begin
        if (addr_lo_r[1]) begin
          merge_word_s = {wdata_r[15:0], mem_read_data[15:0]};
        end else begin
          merge_word_s = {mem_read_data[31:16], wdata_r[15:0]};
        end
      end
      default: merge_word_s = mem_read_data;
    endcase
  end

  // Control FSM with all handshake and memory-side outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_error_r <= 1'b0;
      resp_rdata_r <= {XLEN{1'b0}};
      rd_en_r      <= 1'b0;
      wr_en_r      <= 1'b0;
      mem_addr_r   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r  <= {XLEN{1'b0}};
      is_store_r   <= 1'b0;
      funct3_r     <= 3'b000;
      addr_lo_r    <= 2'b00;
      wdata_r      <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            is_store_r  <= req_is_store;
            funct3_r    <= req_funct3;
            addr_lo_r   <= req_addr[1:0];
            wdata_r     <= req_wdata;
            req_ready_r <= 1'b0;
            if (!req_legal_s) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_error_r <= 1'b1;
              resp_rdata_r <= {XLEN{1'b0}};
            end else if (req_is_store && (req_funct3 == F3_W)) begin
              state_r     <= WR;
              wr_en_r     <= 1'b1;
              mem_addr_r  <= req_word_addr_s;
              mem_wdata_r <= req_wdata;
            end else begin
              // Loads and sub-word stores both start by reading the word.
              state_r    <= RD;
              rd_en_r    <= 1'b1;
              mem_addr_r <= req_word_addr_s;
            end
          end
        end
        RD: begin
          rd_en_r <= 1'b0;
          if (is_store_r) begin
            state_r     <= WR;
            wr_en_r     <= 1'b1;
            mem_wdata_r <= merge_word_s;
          end else begin
            state_r      <= RESP;
            mem_addr_r   <= {ADDR_WIDTH{1'b0}};
            resp_valid_r <= 1'b1;
            resp_error_r <= 1'b0;
            resp_rdata_r <= load_ext_s;
          end
        end
        WR: begin
          state_r      <= RESP;
          wr_en_r      <= 1'b0;
          mem_addr_r   <= {ADDR_WIDTH{1'b0}};
          mem_wdata_r  <= {XLEN{1'b0}};
          resp_valid_r <= 1'b1;
          resp_error_r <= 1'b0;
          resp_rdata_r <= {XLEN{1'b0}};
        end
        RESP: begin
          if (resp_ready) begin
            state_r      <= IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_error_r <= 1'b0;
            resp_rdata_r <= {XLEN{1'b0}};
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_error_r <= 1'b0;
          resp_rdata_r <= {XLEN{1'b0}};
          rd_en_r      <= 1'b0;
          wr_en_r      <= 1'b0;
          mem_addr_r   <= {ADDR_WIDTH{1'b0}};
          mem_wdata_r  <= {XLEN{1'b0}};
        end
      endcase
    end
  end

  // Strobes are gated by rst so a reset landing on an RD/WR cycle
  // cannot touch memory; address/data read as zero without a strobe.
  assign req_ready        = req_ready_r && !rst;
  assign mem_read_enable  = rd_en_r && !rst;
  assign mem_write_enable = wr_en_r && !rst;
  assign mem_addr         = (mem_read_enable || mem_write_enable) ? mem_addr_r
                                                                  : {ADDR_WIDTH{1'b0}};
  assign mem_write_data   = mem_write_enable ? mem_wdata_r : {XLEN{1'b0}};
  assign resp_valid       = resp_valid_r;
  assign resp_error       = resp_error_r;
  assign resp_rdata       = resp_rdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small
// word-addressed memory (combinational read, posedge write).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:63];
  int rd_cnt = 0;
  int wr_cnt = 0;
  int wr_run = 0;
  int max_wr_run = 0;
  int overlap_cnt = 0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_is_store     (req_is_store),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_addr         (mem_addr),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  assign mem_read_data = mem[mem_addr[7:2]];

  // Memory write port plus strobe bookkeeping.
  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_addr[7:2]] <= mem_write_data;
      wr_cnt <= wr_cnt + 1;
      wr_run <= wr_run + 1;
      if (wr_run + 1 > max_wr_run) max_wr_run <= wr_run + 1;
    end else begin
      wr_run <= 0;
    end
    if (mem_read_enable) rd_cnt <= rd_cnt + 1;
    if (mem_read_enable && mem_write_enable) overlap_cnt <= overlap_cnt + 1;
  end

  // Issue one request, measure latency in cycles after acceptance, and
  // optionally release the response.
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic rel,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output logic rdy, output int rd_d, output int wr_d);
    int rd0;
    int wr0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    rdy = req_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    rdata = resp_rdata;
    err = resp_error;
    if (rel) begin
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
    end
    rd_d = rd_cnt - rd0;
    wr_d = wr_cnt - wr0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_req_ready_low: got %b want 0", req_ready); end
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    tests_run++; if (resp_rdata !== 32'h0 || resp_error !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_data: got %h/%b want 0/0", resp_rdata, resp_error); end
    tests_run++; if (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_strobes: got %b%b want 00", mem_read_enable, mem_write_enable); end
    tests_run++; if (mem_addr !== 32'h0 || mem_write_data !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_write_data); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready_idle: got %b want 1", req_ready); end
  endtask

  task automatic test_store_word();
    int lat; logic [31:0] rd; logic err; logic rdy; int rdd; int wrd;
    run_req(1'b1, 3'b010, 32'h40, 32'h8899AABB, 1'b1, lat, rd, err, rdy, rdd, wrd);
    tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL sw_ready: got %b want 1", rdy); end
    tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL sw_latency: got %0d want 2", lat); end
    tests_run++; if (err !== 1'b0 || rd !== 32'h0) begin tests_failed++; $display("FAIL sw_resp: got %h/%b want 0/0", rd, err); end
    tests_run++; if (wrd !== 1 || rdd !== 0) begin tests_failed++; $display("FAIL sw_strobes: got rd=%0d wr=%0d want 0/1", rdd, wrd); end
    tests_run++; if (mem[16] !== 32'h8899AABB) begin tests_failed++; $display("FAIL sw_mem40: got %h want 8899aabb", mem[16]); end
    run_req(1'b1, 3'b010, 32'h80, 32'hDEADBEEF, 1'b1, lat, rd, err, rdy, rdd, wrd);
    tests_run++; if (mem[32] !== 32'hDEADBEEF || wrd !== 1) begin tests_failed++; $display("FAIL sw_mem80: got %h wr=%0d want deadbeef wr=1", mem[32], wrd); end
    run_req(1'b0, 3'b010, 32'h80, 32'h0, 1'b1, lat, rd, err, rdy, rdd, wrd);
    tests_run++; if (rd !== 32'hDEADBEEF || lat !== 2) begin tests_failed++; $display("FAIL lw_after_sw: got %h lat=%0d want deadbeef lat=2", rd, lat); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3_t  [8] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b101, 3'b000, 3'b001, 3'b100};
    logic [31:0] adr_t [8] = '{32'h43, 32'h43, 32'h42, 32'h40, 32'h40, 32'h40, 32'h40, 32'h41};
    logic [31:0] exp_t [8] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h8899AABB,
                               32'h0000AABB, 32'hFFFFFFBB, 32'hFFFFAABB, 32'h000000AA};
    int lat; logic [31:0] rd; logic err; logic rdy; int rdd; int wrd;
    for (int k = 0; k < 8; k++) begin
      run_req(1'b0, f3_t[k], adr_t[k], 32'h0, 1'b1, lat, rd, err, rdy, rdd, wrd);
      tests_run++;
      if (rd !== exp_t[k] || lat !== 2 || err !== 1'b0 || rdd !== 1 || wrd !== 0) begin
        tests_failed++;
        $display("FAIL load_%0d: got data=%h lat=%0d err=%b rd=%0d wr=%0d want data=%h lat=2 err=0 rd=1 wr=0",
                 k, rd, lat, err, rdd, wrd, exp_t[k]);
      end
    end
  endtask

  task automatic test_store_sub();
    int lat; logic [31:0] rd; logic err; logic rdy; int rdd; int wrd;
    run_req(1'b1, 3'b000, 32'h41, 32'h12345677, 1'b1, lat, rd, err, rdy, rdd, wrd);
    tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL sb_latency: got %0d want 3", lat); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL sb_error: got %b want 0", err); end
    tests_run++; if (rdd !== 1 || wrd !== 1) begin tests_failed++; $display("FAIL sb_strobes: got rd=%0d wr=%0d want 1/1", rdd, wrd); end
    tests_run++; if (mem[16] !== 32'h889977BB) begin tests_failed++; $display("FAIL sb_merge: got %h want 889977bb", mem[16]); end
    run_req(1'b1, 3'b001, 32'h42, 32'h5555CAFE, 1'b1, lat, rd, err, rdy, rdd, wrd);
    tests_run++; if (mem[16] !== 32'hCAFE77BB || lat !== 3) begin tests_failed++; $display("FAIL sh_merge: got %h lat=%0d want cafe77bb lat=3", mem[16], lat); end
  endtask

  task automatic test_errors();
    logic        st_t  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3_t  [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] adr_t [4] = '{32'h42, 32'h41, 32'h40, 32'h40};
    int lat; logic [31:0] rd; logic err; logic rdy; int rdd; int wrd;
    for (int k = 0; k < 4; k++) begin
      run_req(st_t[k], f3_t[k], adr_t[k], 32'hFFFFFFFF, 1'b1, lat, rd, err, rdy, rdd, wrd);
      tests_run++;
      if (err !== 1'b1 || lat !== 1 || rd !== 32'h0 || rdd !== 0 || wrd !== 0 || mem[16] !== 32'hCAFE77BB) begin
        tests_failed++;
        $display("FAIL error_%0d: got err=%b lat=%0d data=%h rd=%0d wr=%0d mem=%h want 1/1/0/0/0/cafe77bb",
                 k, err, lat, rd, rdd, wrd, mem[16]);
      end
    end
  endtask

  task automatic test_back_to_back_hold();
    int lat; logic [31:0] rd; logic err; logic rdy; int rdd; int wrd;
    int bad;
    run_req(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, lat, rd, err, rdy, rdd, wrd);
    tests_run++; if (rd !== 32'hCAFE77BB || lat !== 2) begin tests_failed++; $display("FAIL hold_first: got %h lat=%0d want cafe77bb lat=2", rd, lat); end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFE77BB || req_ready !== 1'b0) bad++;
    end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad); end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    run_req(1'b0, 3'b100, 32'h40, 32'h0, 1'b1, lat, rd, err, rdy, rdd, wrd);
    tests_run++; if (rdy !== 1'b1 || lat !== 2 || rd !== 32'h000000BB) begin tests_failed++; $display("FAIL hold_next_req: got rdy=%b lat=%0d data=%h want 1/2/000000bb", rdy, lat, rd); end
  endtask

  task automatic test_reset_in_rmw();
    int wr0;
    wr0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b001; req_addr = 32'h42; req_wdata = 32'h00001111;
    @(posedge clk);
    #1 req_valid = 1'b0; req_is_store = 1'b0;
    @(negedge clk);
    tests_run++; if (mem_read_enable !== 1'b1 || mem_addr !== 32'h40) begin tests_failed++; $display("FAIL rmw_rd_cycle: got rd=%b addr=%h want 1/00000040", mem_read_enable, mem_addr); end
    rst = 1'b1;
    #1;
    tests_run++; if (req_ready !== 1'b0 || mem_read_enable !== 1'b0) begin tests_failed++; $display("FAIL rmw_rst_gate: got rdy=%b rd=%b want 0/0", req_ready, mem_read_enable); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_rdata !== 32'h0) begin tests_failed++; $display("FAIL rmw_post_reset_resp: got rdy=%b v=%b e=%b d=%h want 1/0/0/0", req_ready, resp_valid, resp_error, resp_rdata); end
    tests_run++; if (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0 || mem_addr !== 32'h0 || mem_write_data !== 32'h0) begin tests_failed++; $display("FAIL rmw_post_reset_mem: got rd=%b wr=%b a=%h d=%h want 0/0/0/0", mem_read_enable, mem_write_enable, mem_addr, mem_write_data); end
    repeat (2) @(negedge clk);
    tests_run++; if (wr_cnt - wr0 !== 0 || mem[16] !== 32'hCAFE77BB) begin tests_failed++; $display("FAIL rmw_no_write: got wr=%0d mem=%h want 0/cafe77bb", wr_cnt - wr0, mem[16]); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_loads();
    test_store_sub();
    test_errors();
    test_back_to_back_hold();
    test_reset_in_rmw();
    tests_run++; if (overlap_cnt !== 0) begin tests_failed++; $display("FAIL strobe_overlap: got %0d want 0", overlap_cnt); end
    tests_run++; if (max_wr_run !== 1) begin tests_failed++; $display("FAIL write_pulse_width: got %0d want 1", max_wr_run); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
